alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one R-type request at a time, drives registered
// operands/opcode to an external combinational ALU, captures its result two
// edges after acceptance and holds it until the consumer handshakes.
// Optional feature macro: ALU_OVF_TRAP_EN (add/sub overflow flagged illegal,
// result forced to zero).
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_funct,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_carry,
    input  logic        alu_over,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_carry,
    output logic        out_over,
    output logic        out_illegal,
    output logic [15:0] out_count
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned CNT_W   = 16;

    localparam logic [OP_W-1:0] OP_ILL = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0011;
    localparam logic [OP_W-1:0] OP_AND = 4'b0100;
    localparam logic [OP_W-1:0] OP_OR  = 4'b1000;
    localparam logic [OP_W-1:0] OP_SLT = 4'b1010;
    localparam logic [OP_W-1:0] OP_NTA = 4'b1101;
    localparam logic [OP_W-1:0] OP_NOR = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_result_q, out_result_d;
    logic                out_carry_q, out_carry_d;
    logic                out_over_q, out_over_d;
    logic                out_illegal_q, out_illegal_d;
    logic [CNT_W-1:0]    out_count_q, out_count_d;

    logic [OP_W-1:0]     dec_op_c;
    logic                in_ready_c;
    logic                accept_c;
    logic                ovf_trap_c;

    // Fixed funct-to-opcode decode; unknown functs map to the illegal opcode.
    always_comb begin
        dec_op_c = OP_ILL;
        unique case (in_funct)
            FUNCT_W'(6'b100000): dec_op_c = OP_ADD;
            FUNCT_W'(6'b100010): dec_op_c = OP_SUB;
            FUNCT_W'(6'b100100): dec_op_c = OP_AND;
            FUNCT_W'(6'b100101): dec_op_c = OP_OR;
            FUNCT_W'(6'b101010): dec_op_c = OP_SLT;
            FUNCT_W'(6'b111101): dec_op_c = OP_NTA;
            FUNCT_W'(6'b100111): dec_op_c = OP_NOR;
            default:             dec_op_c = OP_ILL;
        endcase
    end

    // Ready when idle, or when the held result is leaving this very cycle.
    always_comb begin
        in_ready_c = 1'b0;
        if (!rst) begin
            in_ready_c = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
        end
        accept_c = in_valid && in_ready_c;
    end

    // Overflow trap only applies to arithmetic opcodes.
    always_comb begin
`ifdef ALU_OVF_TRAP_EN
        ovf_trap_c = ((alu_op_q == OP_ADD) || (alu_op_q == OP_SUB)) && alu_over;
`else
        ovf_trap_c = 1'b0;
`endif
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_carry_d   = out_carry_q;
        out_over_d    = out_over_q;
        out_illegal_d = out_illegal_q;
        out_count_d   = out_count_q;

        if (accept_c) begin
            alu_a_d  = in_rs_val;
            alu_b_d  = in_rt_val;
            alu_op_d = dec_op_c;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (alu_op_q == OP_ILL) begin
                    out_result_d  = '0;
                    out_carry_d   = 1'b0;
                    out_over_d    = 1'b0;
                    out_illegal_d = 1'b1;
                end else begin
                    out_result_d  = ovf_trap_c ? '0 : alu_result;
                    out_carry_d   = alu_carry;
                    out_over_d    = alu_over;
                    out_illegal_d = ovf_trap_c;
                end
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_count_d = out_count_q + CNT_W'(1);
                    state_d     = accept_c ? S_ISSUE : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_carry_q   <= 1'b0;
            out_over_q    <= 1'b0;
            out_illegal_q <= 1'b0;
            out_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_carry_q   <= out_carry_d;
            out_over_q    <= out_over_d;
            out_illegal_q <= out_illegal_d;
            out_count_q   <= out_count_d;
        end
    end

    assign in_ready    = in_ready_c;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_carry   = out_carry_q;
    assign out_over    = out_over_q;
    assign out_illegal = out_illegal_q;
    assign out_count   = out_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: external ALU model, transaction-level reference
// model, per-cycle compare on the falling edge, plus literal spot checks.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_funct = '0;
    logic [31:0] in_rs_val = '0;
    logic [31:0] in_rt_val = '0;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_carry, alu_over;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_carry, out_over, out_illegal;
    logic [15:0] out_count;

    int n_vec = 0;
    int n_err = 0;
    logic cnt_skip = 1'b0;
    logic preload_req = 1'b0;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_over(alu_over),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_carry(out_carry), .out_over(out_over), .out_illegal(out_illegal),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    // ALU behaviour: returns {carry, overflow, result}.
    function automatic logic [33:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic c, v;
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'b0001: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                           v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'b0011: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
                           v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'b0100: r = a & b;
            4'b1000: r = a | b;
            4'b1010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1101: r = ~a;
            4'b1111: r = ~(a | b);
            default: r = '0;
        endcase
        return {c, v, r};
    endfunction

    function automatic logic [3:0] op_of(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b0001;
            6'b100010: return 4'b0011;
            6'b100100: return 4'b0100;
            6'b100101: return 4'b1000;
            6'b101010: return 4'b1010;
            6'b111101: return 4'b1101;
            6'b100111: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    always_comb {alu_carry, alu_over, alu_result} = alu_fn(alu_op, alu_a, alu_b);

    // Reference model: last accepted request, cycles left until the result
    // appears, the expected held result and the handshake count.
    logic [31:0] m_a = '0, m_b = '0, m_res = '0;
    logic [3:0]  m_op = '0;
    logic        m_valid = 1'b0, m_c = 1'b0, m_v = 1'b0, m_ill = 1'b0;
    logic [15:0] m_count = '0;
    int          m_wait = 0;

    function automatic logic exp_ready();
        return !rst && ((m_wait == 0 && !m_valid) || (m_valid && out_ready));
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic acc;
        logic [33:0] t;
        if (rst) begin
            m_a = '0; m_b = '0; m_op = '0; m_res = '0;
            m_valid = 1'b0; m_c = 1'b0; m_v = 1'b0; m_ill = 1'b0;
            m_count = '0; m_wait = 0;
        end else begin
            acc = in_valid && exp_ready();
            if (m_valid && out_ready) begin
                m_count = m_count + 16'd1;
                m_valid = 1'b0;
            end
            if (m_wait != 0) begin
                m_wait = m_wait - 1;
                if (m_wait == 0) begin
                    t = alu_fn(m_op, m_a, m_b);
                    m_valid = 1'b1;
                    if (m_op == 4'b0000) begin
                        m_res = '0; m_c = 1'b0; m_v = 1'b0; m_ill = 1'b1;
                    end else begin
                        m_res = t[31:0]; m_c = t[33]; m_v = t[32]; m_ill = 1'b0;
`ifdef ALU_OVF_TRAP_EN
                        if ((m_op == 4'b0001 || m_op == 4'b0011) && t[32]) begin
                            m_res = '0; m_ill = 1'b1;
                        end
`endif
                    end
                end
            end
            if (acc) begin
                m_a = in_rs_val; m_b = in_rt_val; m_op = op_of(in_funct); m_wait = 2;
            end
            if (preload_req) m_count = 16'hFFFF;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(exp_ready()));
        chk("out_valid", 32'(out_valid), 32'(m_valid && !rst));
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_op", 32'(alu_op), 32'(m_op));
        if (!cnt_skip) chk("out_count", 32'(out_count), 32'(m_count));
        if (m_valid || rst) begin
            chk("out_result", out_result, m_res);
            chk("out_carry", 32'(out_carry), 32'(m_c));
            chk("out_over", 32'(out_over), 32'(m_v));
            chk("out_illegal", 32'(out_illegal), 32'(m_ill));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input int stall);
        in_valid = 1'b1; in_funct = f; in_rs_val = a; in_rt_val = b;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        repeat (stall) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    localparam int NT = 10;
    logic [5:0]  t_f [NT] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b101010,
                              6'b111101, 6'b100111, 6'b111111, 6'b100000, 6'b100000};
    logic [31:0] t_a [NT] = '{32'd10, 32'hF0F0F0F0, 32'h00FF0000, 32'hFFFFFFFF, 32'd5,
                              32'h12345678, 32'h0000FFFF, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [31:0] t_b [NT] = '{32'd3, 32'h0FF00FF0, 32'h000000FF, 32'd1, 32'hFFFFFFFD,
                              32'h0, 32'hFF000000, 32'h1, 32'd1, 32'd1};
    int          t_s [NT] = '{0, 2, 1, 0, 3, 0, 1, 0, 2, 0};

    initial begin
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        rst = 1'b0;
        #1 chk("ready_after_rst", 32'(in_ready), 32'd1);

        // Reset while in CAPTURE abandons the request.
        in_valid = 1'b1; in_funct = 6'b100000; in_rs_val = 32'd1; in_rt_val = 32'd2;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_count", 32'(out_count), 32'd0);
        repeat (3) tick();
        chk("midrst_no_valid", 32'(out_valid), 32'd0);

        // Add 5+7 with latency checks.
        in_valid = 1'b1; in_funct = 6'b100000; in_rs_val = 32'd5; in_rt_val = 32'd7;
        tick();
        in_valid = 1'b0;
        chk("add_op", 32'(alu_op), 32'h1);
        chk("add_valid_n", 32'(out_valid), 32'd0);
        tick();
        chk("add_valid_n1", 32'(out_valid), 32'd0);
        tick();
        chk("add_valid_n2", 32'(out_valid), 32'd1);
        chk("add_result", out_result, 32'd12);
        chk("add_count0", 32'(out_count), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("add_count1", 32'(out_count), 32'd1);

        // Illegal funct.
        in_valid = 1'b1; in_funct = 6'b000000; in_rs_val = 32'h1234; in_rt_val = 32'h55;
        tick();
        in_valid = 1'b0;
        chk("ill_op", 32'(alu_op), 32'h0);
        tick();
        chk("ill_valid_n1", 32'(out_valid), 32'd0);
        tick();
        chk("ill_valid_n2", 32'(out_valid), 32'd1);
        chk("ill_flag", 32'(out_illegal), 32'd1);
        chk("ill_result", out_result, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        for (int i = 0; i < NT; i++) txn(t_f[i], t_a[i], t_b[i], t_s[i]);

        // Backpressure for five cycles, then back-to-back AND.
        in_valid = 1'b1; in_funct = 6'b100101; in_rs_val = 32'hF0; in_rt_val = 32'h0F;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        repeat (5) begin
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_result", out_result, 32'hFF);
            chk("bp_valid", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1; in_valid = 1'b1; in_funct = 6'b100100;
        in_rs_val = 32'hFF00FF00; in_rt_val = 32'h0FF00FF0;
        #1 chk("b2b_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_op", 32'(alu_op), 32'h4);
        chk("b2b_valid0", 32'(out_valid), 32'd0);
        tick();
        chk("b2b_valid1", 32'(out_valid), 32'd0);
        tick();
        chk("b2b_valid2", 32'(out_valid), 32'd1);
        chk("b2b_result", out_result, 32'h0F000F00);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Count wrap from a preloaded 0xFFFF.
        cnt_skip = 1'b1; preload_req = 1'b1;
        force dut.out_count_q = 16'hFFFF;
        tick();
        release dut.out_count_q;
        preload_req = 1'b0; cnt_skip = 1'b0;
        chk("wrap_pre", 32'(out_count), 32'hFFFF);
        txn(6'b100000, 32'd1, 32'd1, 0);
        chk("wrap_post", 32'(out_count), 32'h0);

        // Signed overflow on subtract.
        in_valid = 1'b1; in_funct = 6'b100010; in_rs_val = 32'h7FFFFFFF; in_rt_val = 32'hFFFFFFFE;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("ovf_over", 32'(out_over), 32'd1);
`ifdef ALU_OVF_TRAP_EN
        chk("ovf_illegal", 32'(out_illegal), 32'd1);
        chk("ovf_result", out_result, 32'h0);
`else
        chk("ovf_illegal", 32'(out_illegal), 32'd0);
        chk("ovf_result", out_result, 32'h80000001);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
